img_filter_ctrl: RTL and testbench

//  Frame sequencer for the `image` filter datapath (gray/blur/sobel/invert/bright).
//  - Accepts one frame of 8-bit samples on a valid/ready stream.
//  - Builds 3x3 windows with two line buffers and drives the datapath's sel/value/din0..din8.
//  - Tracks the datapath's 1-cycle latency and returns results on a valid/ready stream with frame-end marking.

---
 rtl/img_filter_ctrl_if.sv | 14 +
 rtl/img_filter_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_img_filter_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_filter_ctrl_if.sv
// Sample-in / result-out stream bundle between the frame sequencer and its source and sink.
// slave is the sequencer side; master is the source/sink side.
interface img_filter_ctrl_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_last;
   logic       m_ready;

   modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
   modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/img_filter_ctrl.sv
// Frame sequencer for the image filter datapath: builds gray/point/3x3 windows from a sample stream,
// tracks the datapath's 1-cycle latency and returns results through a 4-entry FIFO with m_last marking.
module img_filter_ctrl #(
   parameter int MAX_W = 640,
   parameter int DIM_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [7:0]       value,
   input  logic [DIM_W-1:0] img_w,
   input  logic [DIM_W-1:0] img_h,
   output logic             busy,
   output logic             done,
   output logic             err,
   img_filter_ctrl_if.slave strm,
   output logic [2:0]       dp_sel,
   output logic [7:0]       dp_value,
   output logic [7:0]       dp_din0,
   output logic [7:0]       dp_din1,
   output logic [7:0]       dp_din2,
   output logic [7:0]       dp_din3,
   output logic [7:0]       dp_din4,
   output logic [7:0]       dp_din5,
   output logic [7:0]       dp_din6,
   output logic [7:0]       dp_din7,
   output logic [7:0]       dp_din8,
   input  logic [7:0]       dp_dout
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam logic [DIM_W-1:0] MAX_WD = DIM_W'(MAX_W);
   localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);
   localparam logic [DIM_W-1:0] TWO    = DIM_W'(2);
   localparam logic [DIM_W-1:0] THREE  = DIM_W'(3);

   state_t           state, state_nx;
   logic [2:0]       mode_q;
   logic [DIM_W-1:0] w_q, h_q, col, row;
   logic [1:0]       phase;
   logic [7:0]       r_q, g_q;
   logic [7:0]       lb1 [MAX_W];
   logic [7:0]       lb2 [MAX_W];
   logic [7:0]       win_t [2];
   logic [7:0]       win_m [2];
   logic [7:0]       win_b [2];
   logic [7:0]       dp_din_q [9];
   logic [7:0]       din_nx [9];
   logic             p0_vld, p0_last, p1_vld, p1_last;
   logic [8:0]       fifo_mem [4];
   logic [1:0]       wp, rp;
   logic [2:0]       cnt, occ;
   logic             start_ok, s_rdy, accept, is_gray, is_win;
   logic             pix_adv, last_pix, last_beat, issue, push, pop;

   always_comb begin
      start_ok = 1'b1;
      if (img_w == '0 || img_h == '0 || img_w > MAX_WD)
         start_ok = 1'b0;
      if ((mode == 3'b001 || mode == 3'b010) && (img_w < THREE || img_h < THREE))
         start_ok = 1'b0;
   end

   // Occupancy counts results already issued to the datapath, so the FIFO can never overflow.
   assign occ       = cnt + 3'(p0_vld) + 3'(p1_vld);
   assign s_rdy     = (state == RUN) && (occ < 3'd4);
   assign accept    = strm.s_valid && s_rdy;
   assign is_gray   = (mode_q == 3'b000);
   assign is_win    = (mode_q == 3'b001) || (mode_q == 3'b010);
   assign pix_adv   = accept && (!is_gray || phase == 2'd2);
   assign last_pix  = (row == h_q - ONE) && (col == w_q - ONE);
   assign last_beat = pix_adv && last_pix;
   assign issue     = pix_adv && (!is_win || (row >= TWO && col >= TWO));
   assign push      = p1_vld;
   assign pop       = strm.m_valid && strm.m_ready;

   assign strm.s_ready = s_rdy;
   assign strm.m_valid = (cnt != 3'd0);
   assign strm.m_data  = fifo_mem[rp][7:0];
   assign strm.m_last  = (cnt != 3'd0) && fifo_mem[rp][8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != IDLE);
      case (state)
         IDLE:    if (start && start_ok) state_nx = RUN;
         RUN:     if (last_beat) state_nx = DRAIN;
         DRAIN:   if (pop && strm.m_last && cnt == 3'd1 && !p0_vld && !p1_vld) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Window columns: [0] is col-2, [1] is col-1; lb2/lb1 give rows r-2/r-1 of the current column.
   always_comb begin
      din_nx = '{default: 8'h00};
      if (is_gray) begin
         din_nx[0] = r_q;
         din_nx[1] = g_q;
         din_nx[2] = strm.s_data;
      end else if (is_win) begin
         din_nx[0] = win_t[0];
         din_nx[1] = win_t[1];
         din_nx[2] = lb2[col];
         din_nx[3] = win_m[0];
         din_nx[4] = win_m[1];
         din_nx[5] = lb1[col];
         din_nx[6] = win_b[0];
         din_nx[7] = win_b[1];
         din_nx[8] = strm.s_data;
      end else begin
         din_nx[0] = strm.s_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q   <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col      <= '0;
         row      <= '0;
         phase    <= '0;
         r_q      <= '0;
         g_q      <= '0;
         dp_sel   <= '0;
         dp_value <= '0;
         dp_din_q <= '{default: 8'h00};
         p0_vld   <= 1'b0;
         p0_last  <= 1'b0;
         p1_vld   <= 1'b0;
         p1_last  <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= (state == DRAIN) && (state_nx == IDLE);
         err  <= (state == IDLE) && start && !start_ok;
         if (state == IDLE && start && start_ok) begin
            mode_q   <= mode;
            w_q      <= img_w;
            h_q      <= img_h;
            dp_sel   <= mode;
            dp_value <= value;
            col      <= '0;
            row      <= '0;
            phase    <= '0;
         end
         if (accept && is_gray) begin
            case (phase)
               2'd0:    begin r_q <= strm.s_data; phase <= 2'd1; end
               2'd1:    begin g_q <= strm.s_data; phase <= 2'd2; end
               default: phase <= 2'd0;
            endcase
         end
         if (pix_adv) begin
            if (last_pix) begin
               col <= '0;
               row <= '0;
            end else if (col == w_q - ONE) begin
               col <= '0;
               row <= row + ONE;
            end else begin
               col <= col + ONE;
            end
         end
         if (issue) dp_din_q <= din_nx;
         p0_vld  <= issue;
         p0_last <= last_beat;
         p1_vld  <= p0_vld;
         p1_last <= p0_last;
      end
   end

   always_ff @(posedge clk) begin
      if (pix_adv) begin
         lb2[col] <= lb1[col];
         lb1[col] <= strm.s_data;
         win_t[0] <= win_t[1];
         win_m[0] <= win_m[1];
         win_b[0] <= win_b[1];
         win_t[1] <= lb2[col];
         win_m[1] <= lb1[col];
         win_b[1] <= strm.s_data;
      end
      if (push) fifo_mem[wp] <= {p1_last, dp_dout};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 2'd1;
         if (pop)  rp <= rp + 2'd1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 3'd1;
            2'b01:   cnt <= cnt - 3'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign dp_din0 = dp_din_q[0];
   assign dp_din1 = dp_din_q[1];
   assign dp_din2 = dp_din_q[2];
   assign dp_din3 = dp_din_q[3];
   assign dp_din4 = dp_din_q[4];
   assign dp_din5 = dp_din_q[5];
   assign dp_din6 = dp_din_q[6];
   assign dp_din7 = dp_din_q[7];
   assign dp_din8 = dp_din_q[8];
endmodule

// File: tb/tb_img_filter_ctrl.sv
// Bench for img_filter_ctrl: behavioural datapath, frame-level reference model and output scoreboard.
module tb_img_filter_ctrl;
   localparam int MAX_W = 640;
   localparam int DIM_W = 10;
   typedef logic [7:0] bq_t [$];

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [2:0]       mode = '0;
   logic [7:0]       value = '0;
   logic [DIM_W-1:0] img_w = '0;
   logic [DIM_W-1:0] img_h = '0;
   logic             busy, done, err;
   logic [2:0]       dp_sel;
   logic [7:0]       dp_value;
   logic [7:0]       dp_din0, dp_din1, dp_din2, dp_din3, dp_din4, dp_din5, dp_din6, dp_din7, dp_din8;
   logic [7:0]       dp_dout;

   int checks = 0, errors = 0;
   int cyc = 0, acc_cnt = 0, out_cnt = 0, done_cnt = 0, err_cnt = 0;
   int first_acc = -1, first_mv = -1;
   int rdy_mode = 0;
   logic [8:0] sb [$];
   logic [7:0] got [$];
   int dwin [9];

   img_filter_ctrl_if strm ();

   img_filter_ctrl #(.MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .value(value),
      .img_w(img_w), .img_h(img_h), .busy(busy), .done(done), .err(err),
      .strm(strm), .dp_sel(dp_sel), .dp_value(dp_value),
      .dp_din0(dp_din0), .dp_din1(dp_din1), .dp_din2(dp_din2), .dp_din3(dp_din3),
      .dp_din4(dp_din4), .dp_din5(dp_din5), .dp_din6(dp_din6), .dp_din7(dp_din7),
      .dp_din8(dp_din8), .dp_dout(dp_dout)
   );

   always #5 clk = ~clk;

   // Pixel function of the filter datapath, shared by the datapath model and the frame model.
   function automatic int pix_op(input logic [2:0] m, input logic [7:0] v, input int d [9]);
      int r, gx, gy;
      r = 0;
      case (m)
         3'b000: r = (299 * d[0] + 587 * d[1] + 114 * d[2]) / 1000;
         3'b001: begin
            for (int k = 0; k < 9; k++) r += d[k];
            r = r / 9;
         end
         3'b010: begin
            gx = (d[2] + 2 * d[5] + d[8]) - (d[0] + 2 * d[3] + d[6]);
            gy = (d[6] + 2 * d[7] + d[8]) - (d[0] + 2 * d[1] + d[2]);
            r = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (r > 255) r = 255;
         end
         3'b011: r = 255 - d[0];
         3'b100: begin r = d[0] + int'(v); if (r > 255) r = 255; end
         3'b101: begin r = d[0] - int'(v); if (r < 0) r = 0; end
         default: r = 0;
      endcase
      return r;
   endfunction

   always_comb begin
      dwin[0] = int'(dp_din0); dwin[1] = int'(dp_din1); dwin[2] = int'(dp_din2);
      dwin[3] = int'(dp_din3); dwin[4] = int'(dp_din4); dwin[5] = int'(dp_din5);
      dwin[6] = int'(dp_din6); dwin[7] = int'(dp_din7); dwin[8] = int'(dp_din8);
   end

   always @(posedge clk) dp_dout <= 8'(pix_op(dp_sel, dp_value, dwin));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Expected results of a whole frame, computed from the frame contents.
   task automatic model(input logic [2:0] m, input logic [7:0] v, input int w, input int h, input bq_t s);
      int d [9];
      int n, k;
      logic lst;
      if (m == 3'b000) begin
         for (int p = 0; p < w * h; p++) begin
            d = '{default: 0};
            d[0] = int'(s[3*p]); d[1] = int'(s[3*p+1]); d[2] = int'(s[3*p+2]);
            lst = (p == w * h - 1);
            sb.push_back({lst, 8'(pix_op(m, v, d))});
         end
      end else if (m == 3'b001 || m == 3'b010) begin
         n = (w - 2) * (h - 2);
         k = 0;
         for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++) begin
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     d[3*i+j] = int'(s[(r-2+i)*w + (c-2+j)]);
               k++;
               lst = (k == n);
               sb.push_back({lst, 8'(pix_op(m, v, d))});
            end
      end else begin
         for (int p = 0; p < w * h; p++) begin
            d = '{default: 0};
            d[0] = int'(s[p]);
            lst = (p == w * h - 1);
            sb.push_back({lst, 8'(pix_op(m, v, d))});
         end
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : mon
      logic [8:0] e;
      if (!rst) begin
         if (strm.s_valid && strm.s_ready) begin
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
         end
         if (strm.m_valid && first_mv < 0) first_mv = cyc;
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (strm.m_valid && strm.m_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_unexpected: got data %0d, want no output", strm.m_data);
            end else begin
               e = sb.pop_front();
               chk("out_data", int'(strm.m_data), int'(e[7:0]));
               chk("out_last", int'(strm.m_last), int'(e[8]));
            end
            got.push_back(strm.m_data);
            out_cnt++;
         end
      end
   end

   initial begin
      strm.m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       strm.m_ready = 1'b1;
            1:       strm.m_ready = 1'($urandom_range(0, 1));
            default: strm.m_ready = 1'b0;
         endcase
      end
   end

   task automatic do_start(input logic [2:0] m, input logic [7:0] v, input int w, input int h);
      @(posedge clk); #1;
      start = 1'b1; mode = m; value = v; img_w = DIM_W'(w); img_h = DIM_W'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_beats(input bq_t s, input int first, input bit gaps, input int max_cyc, output int nxt);
      int i, g;
      i = first;
      g = 0;
      while (i < s.size() && g < max_cyc) begin
         @(posedge clk); #1;
         strm.s_valid = (gaps && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
         strm.s_data  = s[i];
         @(negedge clk);
         if (strm.s_valid && strm.s_ready) i++;
         g++;
      end
      @(posedge clk); #1;
      strm.s_valid = 1'b0;
      nxt = i;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (busy && g < 3000);
      chk("idle_timeout", int'(busy), 0);
      @(negedge clk);
   endtask

   task automatic run_frame(input logic [2:0] m, input logic [7:0] v, input int w, input int h,
                            input bq_t s, input int rmode, input bit gaps, input bit poke);
      int nexp, d0, a0, o0, e0, nxt;
      rdy_mode = rmode;
      model(m, v, w, h, s);
      nexp = sb.size();
      d0 = done_cnt; a0 = acc_cnt; o0 = out_cnt; e0 = err_cnt;
      got.delete();
      first_acc = -1;
      first_mv = -1;
      do_start(m, v, w, h);
      if (poke) begin
         start = 1'b1; img_w = '0;
         @(posedge clk); #1;
         start = 1'b0;
      end
      send_beats(s, 0, gaps, 5000, nxt);
      chk("beats_sent", nxt, s.size());
      wait_idle();
      chk("done_pulses", done_cnt - d0, 1);
      chk("accepts", acc_cnt - a0, s.size());
      chk("outputs", out_cnt - o0, nexp);
      chk("sb_drained", sb.size(), 0);
      if (poke) chk("busy_start_err", err_cnt - e0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t s;
      int nxt, d0, w, h;
      logic [2:0] m;
      logic [2:0] bad_m [4] = '{3'b001, 3'b011, 3'b011, 3'b010};
      int bad_w [4] = '{2, MAX_W + 1, 4, 5};
      int bad_h [4] = '{3, 2, 0, 2};

      strm.s_valid = 1'b0;
      strm.s_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_s_ready", int'(strm.s_ready), 0);
      chk("rst_m_valid", int'(strm.m_valid), 0);
      chk("rst_m_last", int'(strm.m_last), 0);
      chk("rst_dp_sel", int'(dp_sel), 0);
      chk("rst_dp_value", int'(dp_value), 0);
      for (int k = 0; k < 9; k++) chk($sformatf("rst_dp_din%0d", k), dwin[k], 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset in the middle of a frame with results waiting in the FIFO.
      rdy_mode = 2;
      @(posedge clk); #1;
      s = '{8'd1, 8'd2, 8'd3};
      do_start(3'b011, 8'd0, 4, 2);
      send_beats(s, 0, 1'b0, 50, nxt);
      chk("rst_mid_beats", nxt, 3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_m_valid", int'(strm.m_valid), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_m_valid", int'(strm.m_valid), 0);
      chk("mid_rst_s_ready", int'(strm.s_ready), 0);
      chk("mid_rst_busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Invert, 4x2 ramp.
      s.delete();
      for (int i = 0; i < 8; i++) s.push_back(8'(i));
      run_frame(3'b011, 8'd0, 4, 2, s, 0, 1'b0, 1'b0);
      chk("inv_count", got.size(), 8);
      if (got.size() == 8) begin
         chk("inv_first", int'(got[0]), 255);
         chk("inv_last", int'(got[7]), 248);
      end
      chk("first_latency", first_mv - first_acc, 3);

      // Gray, two RGB pixels.
      s = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
      run_frame(3'b000, 8'd0, 2, 1, s, 0, 1'b0, 1'b0);
      chk("gray_count", got.size(), 2);
      if (got.size() == 2) begin
         chk("gray_px0", int'(got[0]), 76);
         chk("gray_px1", int'(got[1]), 29);
      end

      // Blur on a flat 3x3 frame.
      s.delete();
      for (int i = 0; i < 9; i++) s.push_back(8'd100);
      run_frame(3'b001, 8'd0, 3, 3, s, 0, 1'b0, 1'b0);
      chk("blur_count", got.size(), 1);
      if (got.size() == 1) chk("blur_px", int'(got[0]), 100);
      chk("blur_centre", int'(dp_din4), int'(s[4]));

      // Blur 4x3 random: final window layout is rows 0..2, cols 1..3.
      s.delete();
      for (int i = 0; i < 12; i++) s.push_back(8'($urandom_range(0, 255)));
      run_frame(3'b001, 8'd0, 4, 3, s, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            chk($sformatf("win_din%0d", 3*i+j), dwin[3*i+j], int'(s[i*4 + 1 + j]));

      // Sobel 5x4 with random backpressure and input gaps.
      s.delete();
      for (int i = 0; i < 20; i++) s.push_back(8'($urandom_range(0, 255)));
      run_frame(3'b010, 8'd0, 5, 4, s, 1, 1'b1, 1'b0);
      chk("sobel_count", got.size(), 6);

      // Output stalled: exactly four results may be outstanding before s_ready drops.
      s.delete();
      for (int i = 0; i < 8; i++) s.push_back(8'($urandom_range(0, 255)));
      model(3'b100, 8'd10, 4, 2, s);
      d0 = done_cnt;
      rdy_mode = 2;
      @(posedge clk); #1;
      do_start(3'b100, 8'd10, 4, 2);
      send_beats(s, 0, 1'b0, 15, nxt);
      chk("fill_accepts", nxt, 4);
      @(negedge clk);
      chk("fill_s_ready", int'(strm.s_ready), 0);
      rdy_mode = 0;
      send_beats(s, nxt, 1'b0, 5000, nxt);
      chk("fill_rest", nxt, 8);
      wait_idle();
      chk("fill_done", done_cnt - d0, 1);
      chk("fill_sb", sb.size(), 0);

      // Illegal starts.
      for (int t = 0; t < 4; t++) begin
         do_start(bad_m[t], 8'd0, bad_w[t], bad_h[t]);
         @(negedge clk);
         chk($sformatf("illegal%0d_err", t), int'(err), 1);
         chk($sformatf("illegal%0d_busy", t), int'(busy), 0);
         chk($sformatf("illegal%0d_s_ready", t), int'(strm.s_ready), 0);
         @(negedge clk);
         chk($sformatf("illegal%0d_err_pulse", t), int'(err), 0);
      end

      // Random frames; the first carries a start while busy.
      for (int t = 0; t < 8; t++) begin
         m = 3'($urandom_range(0, 7));
         if (m == 3'b001 || m == 3'b010) begin
            w = $urandom_range(3, 6); h = $urandom_range(3, 5);
         end else begin
            w = $urandom_range(1, 6); h = $urandom_range(1, 4);
         end
         s.delete();
         for (int i = 0; i < (m == 3'b000 ? 3 : 1) * w * h; i++) s.push_back(8'($urandom_range(0, 255)));
         run_frame(m, 8'($urandom_range(0, 255)), w, h, s, 1, 1'b1, t == 0);
         chk("rand_sel", int'(dp_sel), int'(m));
      end

      chk("sb_final", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
